ate_seq: RTL and testbench
==========================

Name: ate_seq

Overview:
Frame sequencer for the adaptive-threshold engine. On a start pulse it reads a raster greyscale image from a synchronous ROM in 8x8 block order and streams one pixel per cycle to the engine. It then writes the engine's binarized result for each pixel back to its raster address in a result RAM. It holds the engine in reset between frames so the engine's free-running block counter is aligned to pixel 0.

Parameters:
IMG_W, 48, image width in pixels (multiple of BLK)
IMG_H, 32, image height in pixels (multiple of BLK)
BLK, 8, block edge in pixels; a block holds BLK*BLK pixels
AW, 11, address width; must satisfy 2^AW >= IMG_W*IMG_H
LAT, 65, cycles from a pixel's first STREAM cycle to its bin appearing on bin_in

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
start  in  1  one-cycle frame start request
busy  out  1  high from FILL through DRAIN
done  out  1  one-cycle pulse at frame end
rom_addr  out  AW  raster pixel read address
rom_rd  out  1  ROM read enable; data is valid the next cycle
rom_data  in  8  ROM read data
eng_rst  out  1  engine reset, active-high
pix_data  out  8  pixel to engine
bin_in  in  1  engine binary output
thr_in  in  8  engine threshold output
ram_addr  out  AW  result RAM write address
ram_we  out  1  result RAM write enable
ram_wdata  out  1  result bit

Behaviour:
- Reset values: busy=0, done=0, rom_rd=0, rom_addr=0, eng_rst=1, ram_we=0, ram_addr=0, ram_wdata=0. FSM state is IDLE and all counters are 0. Reset mid-frame aborts immediately; there is no partial done.
- FSM has five states: IDLE, FILL, STREAM, DRAIN, DONE.
- IDLE:
  - eng_rst=1.
  - start=1 moves the FSM to FILL. start is ignored in every other state.
- FILL (1 cycle):
  - rom_rd=1, rom_addr=address of pixel 0, eng_rst=1.
  - Moves to STREAM.
- STREAM (N=IMG_W*IMG_H cycles, k=0..N-1):
  - eng_rst=0. pix_data=rom_data, which holds pixel k.
  - rom_rd=1 with rom_addr=address of pixel k+1. rom_rd=0 in the last STREAM cycle.
  - After cycle N-1, moves to DRAIN.
- DRAIN (LAT cycles):
  - pix_data=0, rom_rd=0, eng_rst=0.
  - After LAT cycles, moves to DONE.
- DONE (1 cycle):
  - done=1, eng_rst=1.
  - Moves to IDLE.
- pix_data is 0 in every state except STREAM.
- Block order:
  - Blocks are visited row-major: bcol runs 0..IMG_W/BLK-1, then brow increments.
  - Within a block, pixels run row-major: r, c in 0..BLK-1.
  - Address = (brow*BLK+r)*IMG_W + bcol*BLK + c.
  - Address is computed with incremental counters (c, r, bcol, brow). No multiplier.
- Write side:
  - A second counter set is used, identical to the read set and lagging it by LAT cycles.
  - In the STREAM/DRAIN cycle numbered k+LAT (counting from STREAM cycle 0): ram_we=1, ram_addr=address of pixel k, ram_wdata=bin_in.
  - Exactly N writes per frame. The last write occurs in the final DRAIN cycle.
  - ram_we=0 in every other cycle.
- Overlap: when LAT < N, reads and writes overlap in STREAM. Both counter sets advance independently in that window.
- Counter wrap:
  - c wraps to 0 and increments r.
  - r wraps to 0 and increments bcol.
  - bcol wraps to 0 and increments brow.
  - brow stops after IMG_H/BLK-1.
- Total frame: start sampled in cycle S, done high in cycle S+2+N+LAT.

Optional Feature:
- Macro: ATE_THR_LOG_EN.
- When defined, three extra outputs are added:
  - thr_we (1 bit)
  - thr_addr (AW-6 bits, block index = brow*(IMG_W/BLK)+bcol)
  - thr_wdata (8 bits)
- On every write-side cycle where the write pixel's r=0 and c=0: thr_we=1, thr_wdata=thr_in, thr_addr=the block index of that pixel.
- This produces IMG_W*IMG_H/(BLK*BLK) log writes per frame.
- When undefined, these ports and logic are absent.

Test Plan:
- Reset: assert reset mid-STREAM -> next cycle busy=0, ram_we=0, eng_rst=1. A subsequent start runs a full frame with done at S+2+N+LAT (1603 for the defaults).
- Address order: ROM holds value = addr[7:0]. pix_data in STREAM cycles 0..9 = 0,1,2,3,4,5,6,7,48,49. Cycle 64 = 8, which is the first pixel of block 1.
- Write mapping: bin_in driven as pix_data delayed LAT cycles, bit0 -> RAM contents equal ROM bit0 at every raster address; exactly 1536 writes.
- Start ignored: pulse start during STREAM and DRAIN -> no restart, single done pulse.
- Back-to-back: start held high continuously -> a new frame begins in the cycle after done. eng_rst is high for exactly IDLE+FILL cycles between frames.
- ATE_THR_LOG_EN: thr_in = block-counter stub -> 24 thr_we pulses with thr_addr 0..23 in order, each coinciding with the ram_we of a block's pixel (0,0).

Source files
------------

// File: rtl/ate_seq.sv
// Frame sequencer for the adaptive-threshold engine: reads an image in 8x8 block order,
// streams it to the engine and writes each binarized pixel back to its raster address.
// Optional threshold log ports are enabled by defining ATE_THR_LOG_EN.
module ate_seq #(
  parameter int IMG_W = 48,
  parameter int IMG_H = 32,
  parameter int BLK   = 8,
  parameter int AW    = 11,
  parameter int LAT   = 65
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_addr,
  output logic          rom_rd,
  input  logic [7:0]    rom_data,
  output logic          eng_rst,
  output logic [7:0]    pix_data,
  input  logic          bin_in,
  input  logic [7:0]    thr_in,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          ram_wdata
`ifdef ATE_THR_LOG_EN
  ,
  output logic          thr_we,
  output logic [AW-7:0] thr_addr,
  output logic [7:0]    thr_wdata
`endif
);

  localparam int N   = IMG_W * IMG_H;
  localparam int NBX = IMG_W / BLK;
  localparam int NBY = IMG_H / BLK;
  localparam int CW  = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int XW  = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int YW  = (NBY > 1) ? $clog2(NBY) : 1;
  localparam int TW  = $clog2(N + LAT + 1);

  localparam logic [CW-1:0] C_MAX     = CW'(BLK - 1);
  localparam logic [XW-1:0] X_MAX     = XW'(NBX - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(NBY - 1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(IMG_W - BLK + 1);
  localparam logic [AW-1:0] BLK_STEP  = AW'(1 - (BLK - 1) * IMG_W);
  localparam logic [TW-1:0] T_LAST_RD = TW'(N - 1);
  localparam logic [TW-1:0] T_END     = TW'(N + LAT - 1);
  localparam logic [TW-1:0] T_LAT     = TW'(LAT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [YW-1:0] brow;
    logic [XW-1:0] bcol;
    logic [CW-1:0] r;
    logic [CW-1:0] c;
    logic [AW-1:0] addr;
  } pos_t;

  // Step one pixel along block order; the address moves by constant deltas, and the
  // position saturates on the last pixel of the frame.
  function automatic pos_t adv(input pos_t p);
    pos_t n;
    n = p;
    if (p.c != C_MAX) begin
      n.c    = p.c + CW'(1);
      n.addr = p.addr + AW'(1);
    end else if (p.r != C_MAX) begin
      n.c    = '0;
      n.r    = p.r + CW'(1);
      n.addr = p.addr + ROW_STEP;
    end else if (p.bcol != X_MAX) begin
      n.c    = '0;
      n.r    = '0;
      n.bcol = p.bcol + XW'(1);
      n.addr = p.addr + BLK_STEP;
    end else if (p.brow != Y_MAX) begin
      n.c    = '0;
      n.r    = '0;
      n.bcol = '0;
      n.brow = p.brow + YW'(1);
      n.addr = p.addr + AW'(1);
    end else begin
      n = p;
    end
    return n;
  endfunction

  state_t        state, state_next;
  logic [TW-1:0] tick, tick_next;
  pos_t          rd, rd_next;
  pos_t          wr, wr_next;
  logic          busy_next, done_next, eng_rst_next, rom_rd_next, ram_we_next;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_next = state;
    tick_next  = tick;
    rd_next    = rd;
    wr_next    = ram_we ? adv(wr) : wr;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FILL;
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        state_next = STREAM;
        tick_next  = '0;
        rd_next    = adv(rd);
      end
      STREAM: begin
        tick_next = tick + TW'(1);
        rd_next   = adv(rd);
        if (tick == T_LAST_RD) begin
          state_next = DRAIN;
        end else begin
          state_next = STREAM;
        end
      end
      DRAIN: begin
        if (tick == T_END) begin
          state_next = DONE;
          tick_next  = '0;
        end else begin
          state_next = DRAIN;
          tick_next  = tick + TW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        tick_next  = '0;
        rd_next    = '0;
        wr_next    = '0;
      end
      default: begin
        state_next = IDLE;
        tick_next  = '0;
        rd_next    = '0;
        wr_next    = '0;
      end
    endcase

    busy_next    = (state_next == FILL) || (state_next == STREAM) || (state_next == DRAIN);
    done_next    = (state_next == DONE);
    eng_rst_next = !((state_next == STREAM) || (state_next == DRAIN));
    rom_rd_next  = (state_next == FILL) || ((state_next == STREAM) && (tick_next != T_LAST_RD));
    // Write for pixel k lands in frame cycle k+LAT, which is exactly when its bin arrives
    ram_we_next  = ((state_next == STREAM) || (state_next == DRAIN)) && (tick_next >= T_LAT);
  end

  // State, counters and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      rd      <= '0;
      wr      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      eng_rst <= 1'b1;
      rom_rd  <= 1'b0;
      ram_we  <= 1'b0;
    end else begin
      state   <= state_next;
      tick    <= tick_next;
      rd      <= rd_next;
      wr      <= wr_next;
      busy    <= busy_next;
      done    <= done_next;
      eng_rst <= eng_rst_next;
      rom_rd  <= rom_rd_next;
      ram_we  <= ram_we_next;
    end
  end

  assign rom_addr  = rd.addr;
  assign ram_addr  = wr.addr;
  assign pix_data  = (state == STREAM) ? rom_data : 8'd0;
  assign ram_wdata = ram_we & bin_in;

`ifdef ATE_THR_LOG_EN
  logic [AW-7:0] blk_idx, blk_idx_next;

  // Block index of the write-side pixel, bumped as each block's last pixel is written
  always_comb begin
    if (state == DONE) begin
      blk_idx_next = '0;
    end else if (ram_we && (wr.r == C_MAX) && (wr.c == C_MAX)) begin
      blk_idx_next = blk_idx + (AW-6)'(1);
    end else begin
      blk_idx_next = blk_idx;
    end
  end

  // Block index register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_idx <= '0;
    end else begin
      blk_idx <= blk_idx_next;
    end
  end

  assign thr_we    = ram_we && (wr.r == CW'(0)) && (wr.c == CW'(0));
  assign thr_addr  = blk_idx;
  assign thr_wdata = thr_we ? thr_in : 8'd0;
`else
  logic unused_thr;
  assign unused_thr = ^thr_in;
`endif

endmodule

// File: tb/tb_ate_seq.sv
// Self-checking bench for ate_seq: ROM/engine/RAM models around the DUT, expected
// addresses from a div/mod reference of block order.
module tb_ate_seq;
  localparam int IMG_W = 48;
  localparam int IMG_H = 32;
  localparam int BLK   = 8;
  localparam int AW    = 11;
  localparam int LAT   = 65;
  localparam int N     = IMG_W * IMG_H;
  localparam int BSZ   = BLK * BLK;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rom_rd, eng_rst, bin_in, ram_we, ram_wdata;
  logic [AW-1:0] rom_addr, ram_addr;
  logic [7:0]    rom_data, pix_data;
  logic [7:0]    thr_in = 8'd0;
`ifdef ATE_THR_LOG_EN
  logic          thr_we;
  logic [AW-7:0] thr_addr;
  logic [7:0]    thr_wdata;
`endif

  logic [7:0]     rom [0:(1<<AW)-1];
  logic [7:0]     rom_q;
  logic [LAT-1:0] pipe;
  bit             ram_val  [0:N-1];
  bit             ram_seen [0:N-1];
  int             checks = 0;
  int             errors = 0;
  int             pix_tab [0:9] = '{0, 1, 2, 3, 4, 5, 6, 7, 48, 49};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rd) rom_q <= rom[rom_addr];
  end
  assign rom_data = rom_q;

  // Engine stub: bin is pix_data bit0 delayed by LAT cycles
  always @(posedge clk) pipe <= {pipe[LAT-2:0], pix_data[0]};
  assign bin_in = pipe[LAT-1];

  ate_seq #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BLK(BLK), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data), .eng_rst(eng_rst),
    .pix_data(pix_data), .bin_in(bin_in), .thr_in(thr_in), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata)
`ifdef ATE_THR_LOG_EN
    , .thr_we(thr_we), .thr_addr(thr_addr), .thr_wdata(thr_wdata)
`endif
  );

  function automatic int exp_addr(input int k);
    int b, w, nbx;
    nbx = IMG_W / BLK;
    b = k / BSZ;
    w = k % BSZ;
    return ((b / nbx) * BLK + w / BLK) * IMG_W + (b % nbx) * BLK + w % BLK;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_eng_rst"}, eng_rst, 1'b1);
    chk({tag, "_ram_we"}, ram_we, 1'b0);
    chk({tag, "_rom_rd"}, rom_rd, 1'b0);
    chk({tag, "_pix"}, pix_data, 8'd0);
  endtask

  // Caller has start=1 in the current IDLE cycle; returns in the DONE cycle (or after abort)
  task automatic run_frame(input bit addr_rom, input bit glitch, input bit hold, input int abort_at);
    int writes;
    int thr_n;
    writes = 0;
    thr_n  = 0;
    for (int a = 0; a < (1 << AW); a++) rom[a] = addr_rom ? 8'(a) : 8'($urandom);
    for (int a = 0; a < N; a++) begin
      ram_seen[a] = 1'b0;
      ram_val[a]  = 1'b0;
    end
    step();
    if (!hold) start = 1'b0;
    chk("fill_busy", busy, 1'b1);
    chk("fill_rom_rd", rom_rd, 1'b1);
    chk("fill_rom_addr", rom_addr, 0);
    chk("fill_eng_rst", eng_rst, 1'b1);
    chk("fill_ram_we", ram_we, 1'b0);
    for (int t = 0; t < N + LAT; t++) begin
      start  = hold ? 1'b1 : (glitch ? 1'($urandom_range(0, 1)) : 1'b0);
      thr_in = 8'($urandom);
      step();
      if (t == abort_at) begin
        reset = 1'b1;
        #1;
        chk_idle("abort");
        chk("abort_ram_wdata", ram_wdata, 1'b0);
        return;
      end
      chk("run_busy", busy, 1'b1);
      chk("run_done", done, 1'b0);
      chk("run_eng_rst", eng_rst, 1'b0);
      if (t < N) begin
        chk("pix", pix_data, rom[exp_addr(t)]);
        if (addr_rom && t < 10) chk("pix_order", pix_data, pix_tab[t]);
        if (addr_rom && t == 64) chk("pix_blk1", pix_data, 8);
        chk("rom_rd", rom_rd, t < N - 1);
        if (t < N - 1) chk("rom_addr", rom_addr, exp_addr(t + 1));
      end else begin
        chk("drain_pix", pix_data, 8'd0);
        chk("drain_rom_rd", rom_rd, 1'b0);
      end
      chk("ram_we", ram_we, t >= LAT);
      if (ram_we) begin
        writes++;
        if (t >= LAT) chk("ram_addr", ram_addr, exp_addr(t - LAT));
        if (int'(ram_addr) < N) begin
          ram_seen[ram_addr] = 1'b1;
          ram_val[ram_addr]  = ram_wdata;
        end
      end
`ifdef ATE_THR_LOG_EN
      chk("thr_we", thr_we, (t >= LAT) && ((t - LAT) % BSZ == 0));
      if (thr_we) begin
        chk("thr_addr", thr_addr, thr_n);
        chk("thr_wdata", thr_wdata, thr_in);
        thr_n++;
      end
`endif
    end
    start = hold ? 1'b1 : 1'b0;
    step();
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_eng_rst", eng_rst, 1'b1);
    chk("done_ram_we", ram_we, 1'b0);
    chk("done_rom_rd", rom_rd, 1'b0);
    chk("write_count", writes, N);
    for (int a = 0; a < N; a++) chk("ram_bit", {ram_seen[a], ram_val[a]}, {1'b1, rom[a][0]});
`ifdef ATE_THR_LOG_EN
    chk("thr_count", thr_n, N / BSZ);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_ram_wdata", ram_wdata, 1'b0);
    reset = 1'b0;
    step();
    chk_idle("idle");

    // Abort mid-STREAM via reset
    start = 1'b1;
    run_frame(1'b1, 1'b0, 1'b0, 200);
    step();
    reset = 1'b0;
    step();
    chk_idle("post_abort");

    // Full frame, ROM = addr[7:0]
    start = 1'b1;
    run_frame(1'b1, 1'b0, 1'b0, -1);
    step();
    chk_idle("after_f1");

    // Random image with start pulses during STREAM/DRAIN
    start = 1'b1;
    run_frame(1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("no_restart");
    end

    // Back-to-back with start held high
    start = 1'b1;
    run_frame(1'b0, 1'b0, 1'b1, -1);
    step();
    chk("b2b_idle_eng_rst", eng_rst, 1'b1);
    chk("b2b_idle_busy", busy, 1'b0);
    chk("b2b_idle_done", done, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1, -1);
    start = 1'b0;
    step();
    chk_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
